// File: rtl/ocm_pkg.sv
// Shared constants and read-tag type for the on-chip memory arbiter.
package ocm_pkg;

   localparam int OCM_ADDR_W = 15;
   localparam int OCM_DATA_W = 32;
   localparam int OCM_DEPTH  = 25600;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   typedef struct packed {
      logic  valid;
      port_e port;
      logic  oor;
   } rd_tag_t;

endpackage

// File: rtl/ocm_rd_tag_pipe.sv
// Read-tag delay line matching the memory read latency; cleared by reset so
// no response survives a reset.
module ocm_rd_tag_pipe
   import ocm_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    reset_n,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out,
   output logic    busy
);

   rd_tag_t stage_q [RD_LAT];
   rd_tag_t stage_d [RD_LAT];

   always_comb begin
      stage_d[0] = tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // NOTE: unlike a RAM, this array is a handful of control flops, so every
   // stage is reset; otherwise a stale valid could leak out after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         // NOTE: state is updated with non-blocking assignments so every
         // stage samples the pre-edge value of its neighbour.
         for (int i = 0; i < RD_LAT; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
         busy = busy | stage_q[i].valid;
      end
   end

   assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/ocm_arbiter.sv
// Two-port Avalon-MM arbiter for the single-port on-chip memory: A has
// priority, B is guaranteed a slot after A_MAX consecutive A grants.
module ocm_arbiter
   import ocm_pkg::*;
#(
   parameter int ADDR_W = OCM_ADDR_W,
   parameter int DATA_W = OCM_DATA_W,
   parameter int DEPTH  = OCM_DEPTH,
   parameter int RD_LAT = 1,
   parameter int A_MAX  = 4
) (
   input  logic                clk,
   input  logic                reset_n,

   input  logic [ADDR_W-1:0]   a_address,
   input  logic [DATA_W/8-1:0] a_byteenable,
   input  logic                a_read,
   input  logic                a_write,
   input  logic [DATA_W-1:0]   a_writedata,
   output logic                a_waitrequest,
   output logic [DATA_W-1:0]   a_readdata,
   output logic                a_readdatavalid,

   input  logic [ADDR_W-1:0]   b_address,
   input  logic [DATA_W/8-1:0] b_byteenable,
   input  logic                b_read,
   input  logic                b_write,
   input  logic [DATA_W-1:0]   b_writedata,
   output logic                b_waitrequest,
   output logic [DATA_W-1:0]   b_readdata,
   output logic                b_readdatavalid,

   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,

   output logic                err_sticky
);

   localparam int                CNT_W   = $clog2(A_MAX + 1);
   localparam logic [CNT_W-1:0]  A_MAX_C = CNT_W'(A_MAX);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

   logic              req_a, req_b;
   logic              grant_a, grant_b, grant_any;
   logic              iss_write, iss_oor;
   logic [ADDR_W-1:0] iss_addr;
   rd_tag_t           tag_in, tag_out;
   logic              tag_busy;
   logic [DATA_W-1:0] ret_data;

   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              err_q, err_d;
   logic              a_rdv_q, a_rdv_d, b_rdv_q, b_rdv_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

   assign req_a = a_read | a_write;
   assign req_b = b_read | b_write;

   // NOTE: reset_n gates the grant combinationally so the memory is idle and
   // both masters are stalled for the whole time reset is held low.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (reset_n) begin
         if (req_a && (!req_b || (starve_cnt_q < A_MAX_C))) begin
            grant_a = 1'b1;
         end else if (req_b) begin
            grant_b = 1'b1;
         end
      end
   end

   assign grant_any     = grant_a | grant_b;
   assign a_waitrequest = ~reset_n | (req_a & ~grant_a);
   assign b_waitrequest = ~reset_n | (req_b & ~grant_b);

   // Read+write together is issued as a write; write wins in both muxes.
   assign iss_addr  = grant_b ? b_address : a_address;
   assign iss_write = (grant_a & a_write) | (grant_b & b_write);
   assign iss_oor   = {1'b0, iss_addr} >= DEPTH_C;

   assign mem_address    = iss_addr;
   assign mem_byteenable = grant_b ? b_byteenable : a_byteenable;
   assign mem_writedata  = grant_b ? b_writedata  : a_writedata;
   assign mem_write      = iss_write;
   assign mem_chipselect = grant_any & ~iss_oor;
   assign mem_clken      = reset_n & (grant_any | tag_busy);

   always_comb begin
      tag_in       = '0;
      tag_in.valid = grant_any & ~iss_write;
      tag_in.port  = grant_b ? PORT_B : PORT_A;
      tag_in.oor   = iss_oor;
   end

   ocm_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .tag_in  (tag_in),
      .tag_out (tag_out),
      .busy    (tag_busy)
   );

   assign ret_data = tag_out.oor ? '0 : mem_readdata;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_b || !req_b) begin
         starve_cnt_d = '0;
      end else if (grant_a && (starve_cnt_q != A_MAX_C)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end

      err_d = err_q
            | (grant_any & iss_oor)
            | (a_read & a_write)
            | (b_read & b_write);

      a_rdv_d   = tag_out.valid & (tag_out.port == PORT_A);
      b_rdv_d   = tag_out.valid & (tag_out.port == PORT_B);
      a_rdata_d = a_rdv_d ? ret_data : a_rdata_q;
      b_rdata_d = b_rdv_d ? ret_data : b_rdata_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt_q <= '0;
         err_q        <= 1'b0;
         a_rdv_q      <= 1'b0;
         b_rdv_q      <= 1'b0;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         err_q        <= err_d;
         a_rdv_q      <= a_rdv_d;
         b_rdv_q      <= b_rdv_d;
         a_rdata_q    <= a_rdata_d;
         b_rdata_q    <= b_rdata_d;
      end
   end

   assign a_readdatavalid = a_rdv_q;
   assign b_readdatavalid = b_rdv_q;
   assign a_readdata      = a_rdata_q;
   assign b_readdata      = b_rdata_q;
   assign err_sticky      = err_q;

endmodule

// File: tb/tb_ocm_arbiter.sv
// Directed bench for ocm_arbiter with a behavioural 1-cycle-latency RAM
// standing in for the on-chip memory.
module tb_ocm_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;

   logic [14:0] a_address, b_address;
   logic [3:0]  a_byteenable, b_byteenable;
   logic        a_read, a_write, b_read, b_write;
   logic [31:0] a_writedata, b_writedata;
   logic        a_waitrequest, b_waitrequest;
   logic [31:0] a_readdata, b_readdata;
   logic        a_readdatavalid, b_readdatavalid;

   logic [14:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata, mem_q;
   logic        err_sticky;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram [0:32767];

   always #5 clk = ~clk;

   ocm_arbiter dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .a_address       (a_address),
      .a_byteenable    (a_byteenable),
      .a_read          (a_read),
      .a_write         (a_write),
      .a_writedata     (a_writedata),
      .a_waitrequest   (a_waitrequest),
      .a_readdata      (a_readdata),
      .a_readdatavalid (a_readdatavalid),
      .b_address       (b_address),
      .b_byteenable    (b_byteenable),
      .b_read          (b_read),
      .b_write         (b_write),
      .b_writedata     (b_writedata),
      .b_waitrequest   (b_waitrequest),
      .b_readdata      (b_readdata),
      .b_readdatavalid (b_readdatavalid),
      .mem_address     (mem_address),
      .mem_byteenable  (mem_byteenable),
      .mem_chipselect  (mem_chipselect),
      .mem_write       (mem_write),
      .mem_writedata   (mem_writedata),
      .mem_clken       (mem_clken),
      .mem_readdata    (mem_q),
      .err_sticky      (err_sticky)
   );

   // Old-data read-during-write RAM with registered address.
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         mem_q <= ram[mem_address];
         if (mem_write) begin
            for (int i = 0; i < 4; i++) begin
               if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            end
         end
      end
   end

   typedef struct {
      logic        a_rd, a_wr;
      logic [14:0] a_addr;
      logic        b_rd, b_wr;
      logic [14:0] b_addr;
      logic        exp_a_wait, exp_b_wait, exp_cs, exp_wr;
      logic [14:0] exp_addr;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic ard, input logic awr, input logic [14:0] aad,
                               input logic brd, input logic bwr, input logic [14:0] bad,
                               input logic eaw, input logic ebw, input logic ecs,
                               input logic ewr, input logic [14:0] ead);
      vec_t v;
      v.a_rd = ard; v.a_wr = awr; v.a_addr = aad;
      v.b_rd = brd; v.b_wr = bwr; v.b_addr = bad;
      v.exp_a_wait = eaw; v.exp_b_wait = ebw;
      v.exp_cs = ecs; v.exp_wr = ewr; v.exp_addr = ead;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      a_read = 1'b0; a_write = 1'b0;
      b_read = 1'b0; b_write = 1'b0;
   endtask

   task automatic wr(input bit port, input logic [14:0] addr, input logic [31:0] data,
                     input logic [3:0] be, input string name);
      @(posedge clk); #1;
      idle_inputs();
      if (port) begin
         b_write = 1'b1; b_address = addr; b_writedata = data; b_byteenable = be;
      end else begin
         a_write = 1'b1; a_address = addr; a_writedata = data; a_byteenable = be;
      end
      @(negedge clk);
      check({name, "_wait"}, {31'd0, port ? b_waitrequest : a_waitrequest}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic rd(input bit port, input logic [14:0] addr, input logic [31:0] exp,
                     input string name);
      int lat;
      lat = 0;
      @(posedge clk); #1;
      idle_inputs();
      if (port) begin
         b_read = 1'b1; b_address = addr;
      end else begin
         a_read = 1'b1; a_address = addr;
      end
      @(negedge clk);
      check({name, "_wait"}, {31'd0, port ? b_waitrequest : a_waitrequest}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (port ? b_readdatavalid : a_readdatavalid) begin
            lat = n;
            break;
         end
      end
      check({name, "_latency"}, lat, 32'd2);
      check({name, "_data"}, port ? b_readdata : a_readdata, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b_run, b_run_max, pulses;

      reset_n = 1'b0;
      idle_inputs();
      a_address = 15'd0; b_address = 15'd0;
      a_byteenable = 4'hF; b_byteenable = 4'hF;
      a_writedata = 32'd0; b_writedata = 32'd0;

      // Requests during reset must be stalled and never reach the memory.
      a_write = 1'b1; a_address = 15'h0010;
      @(negedge clk);
      check("rst_a_wait",  {31'd0, a_waitrequest},  32'd1);
      check("rst_b_wait",  {31'd0, b_waitrequest},  32'd1);
      check("rst_cs",      {31'd0, mem_chipselect}, 32'd0);
      check("rst_mem_wr",  {31'd0, mem_write},      32'd0);
      check("rst_clken",   {31'd0, mem_clken},      32'd0);
      @(posedge clk); #1;
      idle_inputs();
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_a_rdv",  {31'd0, a_readdatavalid}, 32'd0);
      check("post_rst_b_rdv",  {31'd0, b_readdatavalid}, 32'd0);
      check("post_rst_err",    {31'd0, err_sticky},      32'd0);
      check("post_rst_a_data", a_readdata, 32'd0);
      check("post_rst_b_wait", {31'd0, b_waitrequest},   32'd0);

      wr(1'b0, 15'h0010, 32'hA5A5_1234, 4'hF, "a_wr10");
      rd(1'b0, 15'h0010, 32'hA5A5_1234, "a_rd10");

      wr(1'b0, 15'd5, 32'h1122_3344, 4'hF, "a_wr5");
      wr(1'b0, 15'd5, 32'hFFFF_FFFF, 4'b0010, "a_wr5_be");
      rd(1'b0, 15'd5, 32'h1122_FF44, "a_rd5_be");
      check("err_before_oor", {31'd0, err_sticky}, 32'd0);

      // Out-of-range write: accepted, memory not selected, error latched.
      @(posedge clk); #1;
      b_write = 1'b1; b_address = 15'd25600; b_writedata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("oor_cs",     {31'd0, mem_chipselect}, 32'd0);
      check("oor_b_wait", {31'd0, b_waitrequest},  32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("oor_err", {31'd0, err_sticky}, 32'd1);
      rd(1'b1, 15'd25601, 32'd0, "b_rd_oor");

      // Arbitration table, one vector per cycle; starve count starts at zero.
      a_writedata = 32'hA5A5_1234; a_byteenable = 4'hF;
      vecs[0] = mk(1'b1, 1'b0, 15'h10, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b1, 1'b0, 15'h10);
      vecs[1] = mk(1'b0, 1'b0, 15'h00, 1'b1, 1'b0, 15'h5, 1'b0, 1'b0, 1'b1, 1'b0, 15'h05);
      vecs[2] = mk(1'b1, 1'b1, 15'h10, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b1, 1'b1, 15'h10);
      for (int i = 3; i < 13; i++) begin
         if (i == 7 || i == 12)
            vecs[i] = mk(1'b1, 1'b0, 15'h10, 1'b1, 1'b0, 15'h5, 1'b1, 1'b0, 1'b1, 1'b0, 15'h05);
         else
            vecs[i] = mk(1'b1, 1'b0, 15'h10, 1'b1, 1'b0, 15'h5, 1'b0, 1'b1, 1'b1, 1'b0, 15'h10);
      end
      vecs[13] = mk(1'b0, 1'b0, 15'h00, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h00);

      b_run = 0;
      b_run_max = 0;
      @(posedge clk);
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         a_read = vecs[i].a_rd; a_write = vecs[i].a_wr; a_address = vecs[i].a_addr;
         b_read = vecs[i].b_rd; b_write = vecs[i].b_wr; b_address = vecs[i].b_addr;
         @(negedge clk);
         check($sformatf("vec%0d_a_wait", i), {31'd0, a_waitrequest}, {31'd0, vecs[i].exp_a_wait});
         check($sformatf("vec%0d_b_wait", i), {31'd0, b_waitrequest}, {31'd0, vecs[i].exp_b_wait});
         check($sformatf("vec%0d_cs", i),     {31'd0, mem_chipselect}, {31'd0, vecs[i].exp_cs});
         check($sformatf("vec%0d_wr", i),     {31'd0, mem_write},      {31'd0, vecs[i].exp_wr});
         if (vecs[i].exp_cs)
            check($sformatf("vec%0d_addr", i), {17'd0, mem_address}, {17'd0, vecs[i].exp_addr});
         b_run = b_waitrequest ? b_run + 1 : 0;
         if (b_run > b_run_max) b_run_max = b_run;
      end
      check("b_wait_run_max", b_run_max, 32'd4);
      @(posedge clk); #1;
      idle_inputs();
      repeat (4) @(posedge clk);

      wr(1'b0, 15'd1, 32'h1111_0001, 4'hF, "a_wr1");
      wr(1'b1, 15'd2, 32'h2222_0002, 4'hF, "b_wr2");
      wr(1'b0, 15'd3, 32'h3333_0003, 4'hF, "a_wr3");

      // Interleaved reads on consecutive cycles return in issue order.
      @(posedge clk); #1;
      a_read = 1'b1; a_address = 15'd1;
      @(posedge clk); #1;
      idle_inputs(); b_read = 1'b1; b_address = 15'd2;
      @(posedge clk); #1;
      idle_inputs(); a_read = 1'b1; a_address = 15'd3;
      @(negedge clk);
      check("il0_a_rdv",  {31'd0, a_readdatavalid}, 32'd1);
      check("il0_b_rdv",  {31'd0, b_readdatavalid}, 32'd0);
      check("il0_a_data", a_readdata, 32'h1111_0001);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("il1_b_rdv",  {31'd0, b_readdatavalid}, 32'd1);
      check("il1_a_rdv",  {31'd0, a_readdatavalid}, 32'd0);
      check("il1_b_data", b_readdata, 32'h2222_0002);
      @(negedge clk);
      check("il2_a_rdv",  {31'd0, a_readdatavalid}, 32'd1);
      check("il2_b_rdv",  {31'd0, b_readdatavalid}, 32'd0);
      check("il2_a_data", a_readdata, 32'h3333_0003);
      repeat (3) @(posedge clk);

      // Reset one cycle after a read grant discards the in-flight response.
      @(posedge clk); #1;
      a_read = 1'b1; a_address = 15'h0010;
      @(negedge clk);
      check("mid_rst_grant", {31'd0, a_waitrequest}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      pulses = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (a_readdatavalid || b_readdatavalid) pulses++;
      end
      check("mid_rst_no_rdv", pulses, 32'd0);
      check("mid_rst_err",    {31'd0, err_sticky}, 32'd0);
      check("mid_rst_a_data", a_readdata, 32'd0);
      rd(1'b0, 15'h0010, 32'hA5A5_1234, "a_rd_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ocm_arbiter.md
Name: ocm_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the single-port 32-bit on-chip memory (25600 words, 15-bit word address, byte enables, 1-cycle read latency).
- Port A is the high-priority streaming client (camera/frame path).
- Port B is the Nios data master.
- Bounded-starvation priority scheme; drives the memory's chipselect/write/clken; returns read data with fixed-latency readdatavalid tagged to the issuing port.

Parameters:
- ADDR_W, 15, word address width
- DATA_W, 32, data width; byte enable width is DATA_W/8
- DEPTH, 25600, valid words; addresses >= DEPTH are out of range
- RD_LAT, 1, memory read latency in cycles (1 or 2)
- A_MAX, 4, maximum consecutive A grants while B waits

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- a_address  in  ADDR_W  port A word address
- a_byteenable  in  4  port A byte enables
- a_read  in  1  port A read request
- a_write  in  1  port A write request
- a_writedata  in  DATA_W  port A write data
- a_waitrequest  out  1  port A stall
- a_readdata  out  DATA_W  port A read data
- a_readdatavalid  out  1  port A read data valid
- b_*  same seven signals as port A, for port B
- mem_address  out  ADDR_W  memory address
- mem_byteenable  out  4  memory byte enables
- mem_chipselect  out  1  memory select
- mem_write  out  1  memory write
- mem_writedata  out  DATA_W  memory write data
- mem_clken  out  1  memory clock enable
- mem_readdata  in  DATA_W  memory q output
- err_sticky  out  1  set on out-of-range or read+write protocol error

Behaviour:
- Reset (async assert, sync deassert in system): starve_cnt=0, read-tag pipeline cleared, err_sticky=0, both readdatavalid=0, both readdata=0. While reset_n=0: mem_chipselect=0, mem_write=0, mem_clken=0, both waitrequests=1.
- Request: req_x = x_read | x_write. If both are high, treat as a write and set err_sticky.
- Grant is combinational, one per cycle:
  - only one requester -> grant it;
  - both requesting and starve_cnt < A_MAX -> grant A;
  - both requesting and starve_cnt == A_MAX -> grant B.
- starve_cnt:
  - increments when A is granted while B requests;
  - clears when B is granted or B is idle;
  - saturates at A_MAX.
- x_waitrequest = req_x & ~grant_x. Waitrequest is asserted with no request present only during reset.
- Granted transaction is issued the same cycle: mem_address/byteenable/writedata come from the granted port; mem_write=granted write; mem_chipselect=1 if address < DEPTH.
- mem_clken=1 whenever any grant or in-flight read exists, else 0.
- Out-of-range address (>= DEPTH): the transaction is still accepted (no hang). mem_chipselect=0, the write is dropped, err_sticky is set. A read returns 0 with normal latency.
- Read return:
  - a tag {valid, port, oor} shifts through an RD_LAT-deep pipeline;
  - at exit, the selected port's readdatavalid pulses for 1 cycle and readdata = mem_readdata (or 0 if oor);
  - readdata is registered, so total latency is RD_LAT+1 cycles from grant.
- Full throughput: back-to-back reads from either or both ports, one per cycle, returned in issue order.
- Writes produce no response.
- err_sticky clears only on reset.
- Reset mid-operation: in-flight read tags are discarded; no readdatavalid is emitted after reset release for pre-reset reads.

Decomposition:
- Package ocm_pkg holds:
  - constants OCM_ADDR_W=15, OCM_DATA_W=32, OCM_DEPTH=25600;
  - rd_tag_t struct {valid, port, oor}.
- One sub-module, ocm_rd_tag_pipe: RD_LAT-deep tag shift register with async active-low clear.
- Grant logic and starve counter stay in the top module.

Test Plan:
- Reset -> after release, all readdatavalid=0, err_sticky=0. A reads addr 0x0010 after writing 0xA5A5_1234 -> a_readdatavalid at grant+2 with 0xA5A5_1234.
- A and B both continuously request -> grant pattern AAAAB repeating (A_MAX=4). B waitrequest never exceeds 4 consecutive cycles.
- Byteenable 4'b0010 write of 0xFFFF_FFFF over 0x1122_3344 at addr 5 -> read returns 0x1122_FF44.
- B write to addr 25600 -> mem_chipselect=0, b_waitrequest=0, err_sticky=1. B read of 25601 -> readdata 0 with normal latency.
- Interleaved A/B reads each cycle (A@1, B@2, A@3) -> valid pulses in order A,B,A on consecutive cycles with correct data.
- Assert reset_n low one cycle after a read grant -> no readdatavalid after release; a new read completes normally.
